// File: rtl/arm_pkg.sv
// Shared constants and types for the ARM core front end.
package arm_pkg;
    localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: loads a fetched word, holds, or flushes to a bubble.
module ifid_reg
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_instr,
    output logic        o_id_valid
);
    logic [31:0] r_id_pc;
    logic [31:0] r_id_instr;
    logic        r_id_valid;

    // Flush wins over load; id_pc is left alone on a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_pc    <= 32'h0;
            r_id_instr <= NOP_WORD;
            r_id_valid <= 1'b0;
        end else if (i_flush) begin
            r_id_instr <= NOP_WORD;
            r_id_valid <= 1'b0;
        end else if (i_load) begin
            r_id_pc    <= i_pc;
            r_id_instr <= i_instr;
            r_id_valid <= 1'b1;
        end
    end

    assign o_id_pc    = r_id_pc;
    assign o_id_instr = r_id_instr;
    assign o_id_valid = r_id_valid;
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC, RUN/HALT state, delivered-instruction counter.
module fetch_ctrl
    import arm_pkg::*;
#(
    parameter logic [31:0] PC_RESET     = PC_RESET_DEF,
    parameter bit          HALT_ON_ZERO = 1'b1
)(
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic        restart,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);
    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_count;
    logic         r_halted;

    logic [31:0]  w_target;
    logic         w_zero;
    logic         w_load;
    logic         w_flush;

    assign w_target = {branch_addr[31:2], 2'b00};
    assign w_zero   = HALT_ON_ZERO && (imem_instr == NOP_WORD);

    // In HALT the IF/ID register already holds a bubble, so only RUN drives it.
    always_comb begin
        w_load  = 1'b0;
        w_flush = 1'b0;
        if (r_state == RUN) begin
            if (branch_taken) begin
                w_flush = 1'b1;
            end else if (!freeze) begin
                if (w_zero) w_flush = 1'b1;
                else        w_load  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_pc     <= PC_RESET;
            r_count  <= 32'h0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (branch_taken) begin
                        r_pc <= w_target;
                    end else if (!freeze) begin
                        if (w_zero) begin
                            r_state  <= HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc    <= r_pc + PC_INC;
                            r_count <= r_count + 32'd1;
                        end
                    end
                end
                HALT: begin
                    if (branch_taken) begin
                        r_pc     <= w_target;
                        r_state  <= RUN;
                        r_halted <= 1'b0;
                    end else if (restart) begin
                        r_pc     <= PC_RESET;
                        r_state  <= RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    ifid_reg u_ifid (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_flush    (w_flush),
        .i_pc       (r_pc),
        .i_instr    (imem_instr),
        .o_id_pc    (id_pc),
        .o_id_instr (id_instr),
        .o_id_valid (id_valid)
    );

    assign imem_addr   = r_pc;
    assign halted      = r_halted;
    assign fetch_count = r_count;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl with a small program ROM model.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: halt on zero word
    logic [31:0] a_addr, a_instr, a_baddr, a_id_pc, a_id_instr, a_cnt;
    logic        a_freeze, a_branch, a_restart, a_valid, a_halted;
    // DUT B: no halt on zero word
    logic [31:0] b_addr, b_instr, b_baddr, b_id_pc, b_id_instr, b_cnt;
    logic        b_freeze, b_branch, b_restart, b_valid, b_halted;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] rom(input logic [31:0] addr);
        case (addr)
            32'd0:   rom = 32'h0022_0000;
            32'd4:   rom = 32'h0064_0000;
            32'd8:   rom = 32'h00A6_0000;
            32'd12:  rom = 32'h00E8_1000;
            32'd16:  rom = 32'h016C_0000;
            32'd20:  rom = 32'h01AE_0000;
            default: rom = 32'h0;
        endcase
    endfunction

    assign a_instr = rom(a_addr);
    assign b_instr = rom(b_addr);

    fetch_ctrl #(.PC_RESET(32'h0), .HALT_ON_ZERO(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .imem_addr(a_addr), .imem_instr(a_instr),
        .freeze(a_freeze), .branch_taken(a_branch), .branch_addr(a_baddr),
        .restart(a_restart), .id_pc(a_id_pc), .id_instr(a_id_instr),
        .id_valid(a_valid), .halted(a_halted), .fetch_count(a_cnt)
    );

    fetch_ctrl #(.PC_RESET(32'h0), .HALT_ON_ZERO(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .imem_addr(b_addr), .imem_instr(b_instr),
        .freeze(b_freeze), .branch_taken(b_branch), .branch_addr(b_baddr),
        .restart(b_restart), .id_pc(b_id_pc), .id_instr(b_id_instr),
        .id_valid(b_valid), .halted(b_halted), .fetch_count(b_cnt)
    );

    typedef struct {
        logic        freeze;
        logic        branch;
        logic [31:0] baddr;
        logic        restart;
        logic [31:0] e_pc;
        logic [31:0] e_id_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_halted;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [31:0] pc, input logic [31:0] idpc,
                         input logic [31:0] ins, input logic v, input logic h, input logic [31:0] c);
        chk({tag, " pc"},       a_addr,     pc);
        chk({tag, " id_pc"},    a_id_pc,    idpc);
        chk({tag, " id_instr"}, a_id_instr, ins);
        chk({tag, " id_valid"}, {31'b0, a_valid},  {31'b0, v});
        chk({tag, " halted"},   {31'b0, a_halted}, {31'b0, h});
        chk({tag, " count"},    a_cnt,      c);
    endtask

    function automatic vec_t mk(input logic f, input logic br, input logic [31:0] ba, input logic rs,
                                input logic [31:0] pc, input logic [31:0] idpc, input logic [31:0] ins,
                                input logic v, input logic h, input logic [31:0] c);
        vec_t r;
        r.freeze = f; r.branch = br; r.baddr = ba; r.restart = rs;
        r.e_pc = pc; r.e_id_pc = idpc; r.e_instr = ins;
        r.e_valid = v; r.e_halted = h; r.e_cnt = c;
        return r;
    endfunction

    initial begin
        vecs[0]  = mk(0,0,0,0, 32'd4,  32'd0,  32'h0022_0000, 1,0, 1);
        vecs[1]  = mk(0,0,0,0, 32'd8,  32'd4,  32'h0064_0000, 1,0, 2);
        vecs[2]  = mk(1,0,0,0, 32'd8,  32'd4,  32'h0064_0000, 1,0, 2);
        vecs[3]  = mk(1,0,0,0, 32'd8,  32'd4,  32'h0064_0000, 1,0, 2);
        vecs[4]  = mk(1,0,0,0, 32'd8,  32'd4,  32'h0064_0000, 1,0, 2);
        vecs[5]  = mk(0,0,0,0, 32'd12, 32'd8,  32'h00A6_0000, 1,0, 3);
        vecs[6]  = mk(0,0,0,0, 32'd16, 32'd12, 32'h00E8_1000, 1,0, 4);
        vecs[7]  = mk(0,0,0,0, 32'd20, 32'd16, 32'h016C_0000, 1,0, 5);
        vecs[8]  = mk(0,0,0,0, 32'd24, 32'd20, 32'h01AE_0000, 1,0, 6);
        vecs[9]  = mk(0,0,0,0, 32'd24, 32'd20, 32'h0,         0,1, 6);
        vecs[10] = mk(1,0,0,0, 32'd24, 32'd20, 32'h0,         0,1, 6);
        vecs[11] = mk(0,0,0,1, 32'd0,  32'd20, 32'h0,         0,0, 6);
        vecs[12] = mk(0,0,0,0, 32'd4,  32'd0,  32'h0022_0000, 1,0, 7);
        vecs[13] = mk(0,0,0,0, 32'd8,  32'd4,  32'h0064_0000, 1,0, 8);
        vecs[14] = mk(1,1,32'h11,0, 32'h10, 32'd4, 32'h0,     0,0, 8);
        vecs[15] = mk(0,0,0,0, 32'h14, 32'h10, 32'h016C_0000, 1,0, 9);
        vecs[16] = mk(0,0,0,0, 32'h18, 32'h14, 32'h01AE_0000, 1,0, 10);
        vecs[17] = mk(0,0,0,0, 32'h18, 32'h14, 32'h0,         0,1, 10);
        vecs[18] = mk(0,1,32'd8,0, 32'd8, 32'h14, 32'h0,      0,0, 10);
        vecs[19] = mk(0,0,0,0, 32'd12, 32'd8,  32'h00A6_0000, 1,0, 11);
        vecs[20] = mk(0,0,0,1, 32'd16, 32'd12, 32'h00E8_1000, 1,0, 12);

        a_freeze = 0; a_branch = 0; a_baddr = 0; a_restart = 0;
        b_freeze = 1; b_branch = 0; b_baddr = 0; b_restart = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_a("reset", 32'd0, 32'd0, 32'h0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 21; i++) begin
            a_freeze  = vecs[i].freeze;
            a_branch  = vecs[i].branch;
            a_baddr   = vecs[i].baddr;
            a_restart = vecs[i].restart;
            @(posedge clk);
            #1;
            chk_a($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_id_pc, vecs[i].e_instr,
                  vecs[i].e_valid, vecs[i].e_halted, vecs[i].e_cnt);
            @(negedge clk);
        end
        a_freeze = 0; a_branch = 0; a_restart = 0;

        // Asynchronous reset between edges
        #2;
        rst_n = 0;
        #1;
        chk_a("async_rst", 32'd0, 32'd0, 32'h0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        chk_a("post_rst", 32'd4, 32'd0, 32'h0022_0000, 1, 0, 1);

        // PC wrap with zero-halting disabled
        @(negedge clk);
        b_freeze = 0; b_branch = 1; b_baddr = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        chk("wrap br pc",    b_addr, 32'hFFFF_FFFC);
        chk("wrap br valid", {31'b0, b_valid}, 32'd0);
        @(negedge clk);
        b_branch = 0;
        @(posedge clk);
        #1;
        chk("wrap pc",       b_addr,     32'd0);
        chk("wrap id_pc",    b_id_pc,    32'hFFFF_FFFC);
        chk("wrap id_instr", b_id_instr, 32'h0);
        chk("wrap id_valid", {31'b0, b_valid},  32'd1);
        chk("wrap halted",   {31'b0, b_halted}, 32'd0);
        chk("wrap count",    b_cnt,      32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("wrap2 id_pc",    b_id_pc,    32'd0);
        chk("wrap2 id_instr", b_id_instr, 32'h0022_0000);
        chk("wrap2 count",    b_cnt,      32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the ARM core. Owns the program counter, drives the address of the combinational instruction memory, and registers the returned word into the IF/ID pipeline register. Handles decode-side freeze, branch redirect with flush, and halting on an all-zero (unprogrammed) instruction word. Sits between the instruction memory and the decode stage.

## Interface
Parameters:
- PC_RESET, 32'h0000_0000, PC value after reset and after `restart`
- HALT_ON_ZERO, 1, when 1 a fetched word of 32'h0 halts fetching

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_addr  out  32  instruction-memory address (equals PC register)
- imem_instr  in  32  instruction word, combinational from `imem_addr`
- freeze  in  1  decode hazard stall; hold PC and IF/ID
- branch_taken  in  1  redirect request from execute
- branch_addr  in  32  redirect target
- restart  in  1  leave HALT, resume at PC_RESET
- id_pc  out  32  address of the instruction in `id_instr`
- id_instr  out  32  registered instruction to decode
- id_valid  out  1  `id_instr` is a real instruction
- halted  out  1  controller is in HALT
- fetch_count  out  32  number of instructions delivered (id_valid set), wraps

## Operation
- Two states: RUN, HALT. Reset -> RUN.
- Reset values: pc=PC_RESET, id_pc=0, id_instr=0, id_valid=0, halted=0, fetch_count=0.
- Per-cycle priority in RUN: branch_taken > freeze > normal fetch.
  - branch_taken: pc <= {branch_addr[31:2],2'b00}; id_instr<=0, id_valid<=0 (flush); id_pc unchanged. Ignores freeze.
  - freeze (no branch): pc, id_pc, id_instr, id_valid, fetch_count all held.
  - normal: id_instr<=imem_instr, id_pc<=pc, id_valid<=1, pc<=pc+4, fetch_count+=1.
  - Normal fetch with HALT_ON_ZERO=1 and imem_instr==0: go HALT, pc held, id_valid<=0, id_instr<=0, fetch_count unchanged.
- HALT: pc and id_* held with id_valid=0; freeze ignored.
  - branch_taken: redirect as above, -> RUN.
  - restart (no branch): pc<=PC_RESET, -> RUN. restart in RUN is ignored.
- pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 -> 0. fetch_count wraps at 2^32.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), independent of clk.

## Timing
- All outputs are registered; `imem_addr` is the PC register itself.
- Fetch latency 1 cycle: word at pc=A appears on id_instr with id_pc=A on the edge after imem_addr=A.
- Branch penalty: one bubble (id_valid=0) in the cycle after branch_taken; target instruction valid the following cycle.
- `halted` asserts on the same edge that loads the zero word's flush; deasserts on the redirect/restart edge.
- Throughput: one instruction per cycle when freeze=0.

## Structure
- Shared package `arm_pkg`: PC_RESET default, PC_INC=4, fetch-state enum {RUN, HALT}, NOP/zero-word constant.
- Sub-module `ifid_reg`: the IF/ID register (id_pc, id_instr, id_valid) with load, hold and flush controls; fetch_ctrl holds PC, FSM and counter.

## Test plan
- Reset, program 0x00220000,0x00640000,0x00A60000,0x00E81000,0x016C0000,0x01AE0000 at 0..20, zero beyond -> id_pc 0..20 on consecutive cycles, then halted=1, pc=24, id_valid=0, fetch_count=6.
- freeze high 3 cycles while pc=8 -> id_pc=4, id_instr=0x00640000 held 3 cycles, pc stays 8, then fetch resumes at 8.
- branch_taken with branch_addr=32'h11 and freeze=1 same cycle -> next cycle pc=0x10, id_valid=0; following cycle id_pc=0x10, id_instr=0x016C0000.
- In HALT, restart=1 -> pc=0, halted=0, next id_instr=0x00220000; branch_taken with addr 8 in HALT -> resumes at 8.
- HALT_ON_ZERO=0, branch to 32'hFFFF_FFFC -> pc wraps to 0, id_instr=0 with id_valid=1.
- rst_n low between edges mid-run -> pc=PC_RESET, id_valid=0, fetch_count=0 immediately; fetch restarts at 0 after release.
